// File: rtl/aes_round_key_sequencer.sv
// Steps an external one-round AES-128 key schedule stage through rounds 1..NUM_ROUNDS
// and keeps rk0..rkN for random-access reads. Optional macro KEY_ZEROIZE_EN adds a zeroize input.
module aes_round_key_sequencer #(
    parameter int NUM_ROUNDS    = 10,
    parameter int SCHED_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] cipher_key,
`ifdef KEY_ZEROIZE_EN
    input  logic         zeroize,
`endif
    output logic         busy,
    output logic         done,
    output logic         key_valid,
    output logic [3:0]   ks_round,
    output logic [127:0] ks_key,
    input  logic [127:0] ks_next,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE} state_t;

    localparam logic [3:0] ROUND_IDLE = 4'(NUM_ROUNDS + 1);
    localparam logic [3:0] ROUND_LAST = 4'(NUM_ROUNDS);
    localparam logic [1:0] WAIT_LAST  = 2'(SCHED_LATENCY - 1);

    state_t         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [3:0]     ks_round_q, ks_round_d;
    logic [127:0]   ks_key_q, ks_key_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           key_valid_q, key_valid_d;
    logic [127:0]   rk_q [NUM_ROUNDS+1];
    logic [127:0]   rk_d [NUM_ROUNDS+1];

    logic           wr_en;
    logic [3:0]     wr_idx;
    logic [127:0]   wr_data;
    logic           rk_clr;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ks_round_d  = ks_round_q;
        ks_key_d    = ks_key_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        key_valid_d = key_valid_q;
        wr_en       = 1'b0;
        wr_idx      = ks_round_q;
        wr_data     = ks_next;
        rk_clr      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WAIT;
                    cnt_d       = 2'd0;
                    ks_round_d  = 4'd1;
                    ks_key_d    = cipher_key;
                    busy_d      = 1'b1;
                    key_valid_d = 1'b0;
                    wr_en       = 1'b1;
                    wr_idx      = 4'd0;
                    wr_data     = cipher_key;
                end
            end
            S_WAIT: begin
                // ks_round/ks_key stay frozen until the stage output has settled
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_CAPTURE;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_CAPTURE: begin
                wr_en    = 1'b1;
                ks_key_d = ks_next;
                if (ks_round_q == ROUND_LAST) begin
                    state_d     = S_IDLE;
                    ks_round_d  = ROUND_IDLE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    key_valid_d = 1'b1;
                end else begin
                    state_d    = S_WAIT;
                    ks_round_d = ks_round_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef KEY_ZEROIZE_EN
        if (zeroize) begin
            state_d     = S_IDLE;
            cnt_d       = 2'd0;
            ks_round_d  = ROUND_IDLE;
            ks_key_d    = '0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            key_valid_d = 1'b0;
            wr_en       = 1'b0;
            rk_clr      = 1'b1;
        end
`endif
    end

    always_comb begin
        for (int i = 0; i <= NUM_ROUNDS; i++) begin
            rk_d[i] = rk_q[i];
            if (rk_clr) begin
                rk_d[i] = '0;
            end else if (wr_en && (wr_idx == 4'(i))) begin
                rk_d[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            ks_round_q  <= ROUND_IDLE;
            ks_key_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_valid_q <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ks_round_q  <= ks_round_d;
            ks_key_q    <= ks_key_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            key_valid_q <= key_valid_d;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                rk_q[i] <= rk_d[i];
            end
        end
    end

    // Indices beyond the last round key read as zero
    always_comb begin
        rd_key = '0;
        for (int i = 0; i <= NUM_ROUNDS; i++) begin
            if (rd_round == 4'(i)) begin
                rd_key = rk_q[i];
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign key_valid = key_valid_q;
    assign ks_round  = ks_round_q;
    assign ks_key    = ks_key_q;

endmodule

// File: tb/tb_aes_round_key_sequencer.sv
// Scoreboard bench for aes_round_key_sequencer with a behavioural AES-128 key schedule stage.
// Build with KEY_ZEROIZE_EN defined to also exercise zeroize; override SCHED_LATENCY for latency builds.
module tb_aes_round_key_sequencer;
    parameter int SCHED_LATENCY = 1;
    localparam int NR = 10;

    localparam int K_EXP  = 0;
    localparam int K_ZERO = 1;
    localparam int K_BUSY = 2;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    typedef struct {
        int kind;
        int done_edge;
    } item_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] cipher_key;
    logic         busy, done, key_valid;
    logic [3:0]   ks_round;
    logic [127:0] ks_key, ks_next;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
`ifdef KEY_ZEROIZE_EN
    logic         zeroize;
`endif

    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    item_t exp_q[$];

    aes_round_key_sequencer #(.NUM_ROUNDS(NR), .SCHED_LATENCY(SCHED_LATENCY)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cipher_key(cipher_key),
`ifdef KEY_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .busy(busy), .done(done), .key_valid(key_valid),
        .ks_round(ks_round), .ks_key(ks_key), .ks_next(ks_next),
        .rd_round(rd_round), .rd_key(rd_key)
    );

    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural key schedule stage ----------------
    logic [0:255][7:0] sbox;
    initial sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    function automatic logic [127:0] ks_step(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        case (r)
            4'd1: rc = 8'h01;  4'd2: rc = 8'h02;  4'd3: rc = 8'h04;  4'd4: rc = 8'h08;
            4'd5: rc = 8'h10;  4'd6: rc = 8'h20;  4'd7: rc = 8'h40;  4'd8: rc = 8'h80;
            4'd9: rc = 8'h1b;  4'd10: rc = 8'h36; default: rc = 8'h00;
        endcase
        {w0, w1, w2, w3} = k;
        t  = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    logic [127:0] pipe [SCHED_LATENCY];
    always @(posedge clk) begin
        pipe[0] <= ks_step(ks_key, ks_round);
        for (int i = 1; i < SCHED_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
    assign ks_next = pipe[SCHED_LATENCY-1];

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: handles status items at once, expansion items when done fires
    initial begin : monitor
        item_t it;
        logic  done_prev;
        done_prev = 1'b0;
        rd_round  = 4'd0;
        forever begin
            @(negedge clk);
            if (done === 1'b1 && done_prev === 1'b1)
                chk("done_two_cycles", 128'(done_prev), 128'(1'b0));
            done_prev = done;
            if (done === 1'b1) begin
                tests++;
                if (exp_q.size() == 0 || exp_q[0].kind != K_EXP) begin
                    fails++;
                    $display("[TB] FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
                end else begin
                    it = exp_q.pop_front();
                    chk("done_edge", 128'(cyc), 128'(it.done_edge));
                    chk("done_key_valid", 128'(key_valid), 128'(1'b1));
                    chk("done_busy", 128'(busy), 128'(1'b0));
                    chk("done_ks_round", 128'(ks_round), 128'(4'd11));
                    for (int i = 0; i < 16; i++) begin
                        rd_round = 4'(i);
                        #1;
                        chk($sformatf("rk[%0d]", i), rd_key, (i <= NR) ? FIPS_RK[i] : 128'h0);
                    end
                    $display("[TB] expansion done at edge %0d, keys read back", cyc);
                end
            end else if (exp_q.size() > 0 && exp_q[0].kind != K_EXP) begin
                it = exp_q.pop_front();
                if (it.kind == K_ZERO) begin
                    chk("clr_busy", 128'(busy), 128'(1'b0));
                    chk("clr_done", 128'(done), 128'(1'b0));
                    chk("clr_key_valid", 128'(key_valid), 128'(1'b0));
                    chk("clr_ks_round", 128'(ks_round), 128'(4'd11));
                    chk("clr_ks_key", ks_key, 128'h0);
                    for (int i = 0; i < 16; i++) begin
                        rd_round = 4'(i);
                        #1;
                        chk($sformatf("clr_rk[%0d]", i), rd_key, 128'h0);
                    end
                    $display("[TB] cleared state checked at edge %0d", cyc);
                end else begin
                    chk("acc_busy", 128'(busy), 128'(1'b1));
                    chk("acc_key_valid", 128'(key_valid), 128'(1'b0));
                    chk("acc_ks_round", 128'(ks_round), 128'(4'd1));
                    chk("acc_ks_key", ks_key, FIPS_KEY);
                    $display("[TB] start accepted at edge %0d", cyc);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int done_edge);
        item_t it;
        it.kind      = kind;
        it.done_edge = done_edge;
        exp_q.push_back(it);
    endtask

    task automatic issue_start(input logic [127:0] key, output int e0);
        start      = 1'b1;
        cipher_key = key;
        wait_edges(1);
        start      = 1'b0;
        e0         = cyc;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            wait_edges(1);
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL timeout: %0d items pending after %0d cycles, expected 0", exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    initial begin : stimulus
        int e0;
        rst_n      = 1'b0;
        start      = 1'b0;
        cipher_key = '0;
`ifdef KEY_ZEROIZE_EN
        zeroize    = 1'b0;
`endif
        wait_edges(2);
        push(K_ZERO, 0);
        rst_n = 1'b1;
        wait_drain(10);

        // FIPS-197 expansion with an ignored start at E0+7
        issue_start(FIPS_KEY, e0);
        push(K_EXP, e0 + NR * (SCHED_LATENCY + 1));
        wait_edges(6);
        start      = 1'b1;
        cipher_key = {128{1'b1}};
        wait_edges(1);
        start      = 1'b0;
        wait_drain(60 * (SCHED_LATENCY + 1));
        wait_edges(30);

        // Restart over a valid key set
        issue_start(FIPS_KEY, e0);
        push(K_BUSY, 0);
        push(K_EXP, e0 + NR * (SCHED_LATENCY + 1));
        wait_drain(60 * (SCHED_LATENCY + 1));

        // Reset at E0+9 aborts the expansion
        issue_start(FIPS_KEY, e0);
        push(K_BUSY, 0);
        wait_edges(8);
        rst_n = 1'b0;
        wait_edges(1);
        push(K_ZERO, 0);
        rst_n = 1'b1;
        wait_drain(10);
        wait_edges(30 * (SCHED_LATENCY + 1));

        // Fresh start after the abort completes normally
        issue_start(FIPS_KEY, e0);
        push(K_EXP, e0 + NR * (SCHED_LATENCY + 1));
        wait_drain(60 * (SCHED_LATENCY + 1));

`ifdef KEY_ZEROIZE_EN
        // Zeroize together with start: zeroize wins
        zeroize    = 1'b1;
        start      = 1'b1;
        cipher_key = FIPS_KEY;
        wait_edges(1);
        zeroize    = 1'b0;
        start      = 1'b0;
        push(K_ZERO, 0);
        wait_drain(10);
`endif

        wait_edges(5);
        chk("queue_empty", 128'(exp_q.size()), 128'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_round_key_sequencer.md
Name: aes_round_key_sequencer

Overview:
- Drives the single-step key schedule stage through rounds 1..10 and captures each registered next-round key.
- Stores all 11 round keys (rk0..rk10) in a register file and presents a random-access read port to the cipher round datapath.
- Sits between the key-load interface and the key schedule stage: it feeds the stage's round/key inputs and consumes its registered output.

Parameters:
- NUM_ROUNDS, 10, number of key-schedule steps (AES-128); register file depth is NUM_ROUNDS+1.
- SCHED_LATENCY, 1, clock edges from stable ks_round/ks_key to valid ks_next; legal range 1..4.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle request to expand cipher_key.
- cipher_key  in  128  initial key, sampled on the accepted start edge only.
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse when rk10 is stored.
- key_valid  out  1  register file holds a complete key set.
- ks_round  out  4  binary round number to the key schedule stage.
- ks_key  out  128  current round key to the key schedule stage.
- ks_next  in  128  registered next-round key from the key schedule stage.
- rd_round  in  4  read index 0..10.
- rd_key  out  128  combinational read of rk[rd_round].

Behaviour:
- Reset (rst_n low at posedge):
  - busy=0, done=0, key_valid=0.
  - ks_round=11 (holds the schedule stage frozen), ks_key=0.
  - All rk entries=0; state=IDLE, wait counter=0.
- IDLE:
  - Accept start: rk0<=cipher_key, ks_key<=cipher_key, ks_round<=1, busy<=1, key_valid<=0.
  - Go to WAIT; wait counter<=0.
- WAIT:
  - Hold ks_round and ks_key stable.
  - Increment the counter each edge; after SCHED_LATENCY edges go to CAPTURE.
- CAPTURE (ks_next valid this cycle):
  - rk[ks_round]<=ks_next and ks_key<=ks_next.
  - If ks_round==NUM_ROUNDS: ks_round<=11, busy<=0, done<=1, key_valid<=1, go to IDLE.
  - Else: ks_round<=ks_round+1, go to WAIT.
- Timing:
  - Each round costs SCHED_LATENCY+1 cycles.
  - With start accepted at edge E0, done is high during the cycle after edge E0+NUM_ROUNDS*(SCHED_LATENCY+1); with the default, edge E0+20.
- done is cleared on the following edge; it is never asserted two cycles in a row.
- start while busy: ignored, with no effect on the state or the stored keys.
- start in IDLE with key_valid=1: restarts expansion; key_valid drops on the accepting edge; old rk1..rk10 are retained until overwritten.
- rst_n low mid-expansion: full reset on that edge; a partial key set is never flagged valid.
- rst_n low has priority over start.
- Read port:
  - rd_key=rk[rd_round] for rd_round 0..10; rd_key=0 for rd_round 11..15.
  - The value is meaningful only while key_valid=1.
  - A read of an entry being written returns the old value until the edge.
- ks_round never leaves the set {1..10, 11}; it is 11 whenever busy=0.

Optional Feature:
- Macro: KEY_ZEROIZE_EN.
- Defined: adds input port zeroize (1 bit).
  - zeroize high at posedge clears all rk entries and ks_key to 0.
  - Also forces busy=0, done=0, key_valid=0, ks_round=11 and state=IDLE.
  - Same effect as reset except it is active-high.
  - zeroize wins over start on the same edge.
  - rst_n low wins over zeroize.
- Not defined: no zeroize port; key material is cleared only by rst_n.

Test Plan:
- Bench attaches a behavioural one-step key schedule model with SCHED_LATENCY register stages.
- Reset: hold rst_n=0 for 2 cycles -> busy=0, done=0, key_valid=0, ks_round=11, rd_key=0 for all rd_round.
- FIPS-197 vector, cipher_key=2b7e151628aed2a6abf7158809cf4f3c, start at E0 (SCHED_LATENCY=1):
  - done pulses exactly once, in the cycle after edge E0+20.
  - rd_round=1 -> a0fafe1788542cb123a339392a6c7605.
  - rd_round=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rd_round=0 -> cipher_key.
- Start while busy: pulse start with a different key at E0+7 -> ignored; rk10 still d014f9a8c9ee2589e13f0cc8b6630ca6; done at E0+20 only.
- Reset mid-operation: rst_n=0 at E0+9 -> next cycle key_valid=0, busy=0, ks_round=11, all rk=0; a new start completes normally.
- Out-of-range read after a complete expansion: rd_round=11 and rd_round=15 -> rd_key=0.
- SCHED_LATENCY=3 build: same vector -> done after edge E0+40; identical rk values.
- KEY_ZEROIZE_EN build: zeroize after done -> key_valid=0 and rd_key=0 for rounds 0..10 on the next cycle.
